me_pixel_memory: RTL and testbench
==================================

# me_pixel_memory

Pixel storage for the motion estimator (`top`). It holds the 16×16 reference block (R) and the 31×31 search window (S) as 8-bit pixels. One read port serves R and two independent read ports serve S; all reads are registered. A write port lets the bench or a loader fill either array before `start`, which replaces hierarchical assignment of array contents.

## Interface
Parameters:
- `PIX_W`, default 8: pixel width in bits.
- `R_DIM`, default 16: reference block side; R depth is R_DIM² = 256.
- `S_DIM`, default 31: search window side; S depth is S_DIM² = 961.

Ports:
- `clock`, input, 1: the single clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `AddressR`, input, 8: R read address, row-major (row*16 + col).
- `AddressS1`, input, 10: S read address, port 1, row-major (row*31 + col).
- `AddressS2`, input, 10: S read address, port 2.
- `R`, output, PIX_W: R read data.
- `S1`, output, PIX_W: S port-1 read data.
- `S2`, output, PIX_W: S port-2 read data.
- `load_en`, input, 1: write strobe.
- `load_sel`, input, 1: write target; 0 = R, 1 = S.
- `load_addr`, input, 10: write address; R uses bits [7:0].
- `load_data`, input, PIX_W: write data.
- `load_err`, output, 1: registered flag; 1 for one cycle after a write to an S address ≥ 961.

## Operation
- Storage is two arrays: R[0:255] and S[0:960], each PIX_W bits per entry.
- Reads: on each rising edge, each output register loads its array entry at the current address.
  - `R` ← R[AddressR].
  - `S1` ← S[AddressS1].
  - `S2` ← S[AddressS2].
- Out-of-range S read: an address ≥ 961 loads 0 into the output. It is not an error.
- Every R address is valid, since 8 bits covers exactly 256 entries.
- Writes: when `load_en`=1 at a rising edge, the entry selected by `load_sel` and `load_addr` is written.
  - A write to S with address ≥ 961 is discarded and sets `load_err` for the next cycle.
  - `load_addr[9:8]` is ignored when `load_sel`=0.
- Read and write to the same address in the same cycle: the read returns the old contents (read-before-write). The new value is visible on the next read.
- S1 and S2 may carry the same address; both outputs return identical data.
- Writes and reads may be concurrent at all times. Bench discipline is to load before `start`; the RTL does not enforce it.

## Timing
- Read latency is exactly 1 cycle: address at edge N gives data valid after edge N+1.
- The estimator's pipeline depends on this latency; no bypass, no extra stage.
- Reset (`rst_n`=0, asynchronous):
  - `R`, `S1`, `S2` and `load_err` go to 0 immediately.
  - Array contents are NOT reset; they are retained across reset.
- While `rst_n`=0:
  - Writes are ignored.
  - Outputs are held at 0.
- Reset release: the first registered read occurs at the first rising edge with `rst_n`=1.
- Reset mid-operation: outputs clear at once, memory contents survive, and reads resume cleanly after release.
- Uninitialised entries read as X in simulation. Loading before use is the user's responsibility.

## Structure
Shared package `me_pkg`:
- Constants: `PIX_W`, `R_DIM`, `S_DIM`, `R_DEPTH`=256, `S_DEPTH`=961, `R_AW`=8, `S_AW`=10.
- Typedef `pixel_t` (`logic [PIX_W-1:0]`).
- Enum `mem_sel_e` {SEL_R, SEL_S}.

Sub-module `me_sync_ram`:
- Generic 1-write / N-read registered RAM, parameterised by depth, address width and number of read ports.
- Provides range checking, async-reset output registers and read-before-write behaviour.
- Instantiated twice: R with 1 read port, S with 2 read ports.

The top level handles write decode and `load_err` only.

## Test plan
1. Reset: drive `rst_n`=0 mid-run with nonzero outputs -> `R`/`S1`/`S2`/`load_err` read 0 within the same timestep. After release, previously loaded data is still readable.
2. R fill and readback: write R[i] = i for i = 0..255, then sweep `AddressR` 0..255 -> `R` = `AddressR` one cycle later. Check R[255] = 8'hFF.
3. S dual read: write S[i] = i mod 256. Drive `AddressS1`=0 and `AddressS2`=960 -> `S1`=0 and `S2`=960 mod 256 = 8'hC0 after 1 cycle. Repeat with both addresses = 500 -> both read 8'hF4.
4. Out-of-range S:
   - Read `AddressS1`=961 -> `S1`=0.
   - Write S address 1000 -> `load_err`=1 for exactly one cycle, and S contents are unchanged.
5. Read-before-write: S[10]=8'h11. Write 8'h22 to S[10] while `AddressS1`=10 -> `S1`=8'h11 that cycle and 8'h22 the next.
6. Estimator integration: load R equal to the S sub-block at offset (x=+3, y=−2), pulse `start` -> estimator reports `motionX`=3, `motionY`=−2, `BestDist`=0, and `completed` rises.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimator pixel storage.
package me_pkg;

   localparam int unsigned PIX_W   = 8;
   localparam int unsigned R_DIM   = 16;
   localparam int unsigned S_DIM   = 31;
   localparam int unsigned R_DEPTH = R_DIM * R_DIM;
   localparam int unsigned S_DEPTH = S_DIM * S_DIM;
   localparam int unsigned R_AW    = 8;
   localparam int unsigned S_AW    = 10;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [0:0] {
      SEL_R = 1'b0,
      SEL_S = 1'b1
   } mem_sel_e;

endpackage

// File: rtl/me_sync_ram.sv
// Generic 1-write / N-read RAM with registered, range-checked, read-before-write outputs.
module me_sync_ram #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 256,
   parameter int unsigned AddrW = 8,
   parameter int unsigned NumRd = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         we_i,
   input  logic [AddrW-1:0]             waddr_i,
   input  logic [Width-1:0]             wdata_i,
   input  logic [NumRd-1:0][AddrW-1:0]  raddr_i,
   output logic [NumRd-1:0][Width-1:0]  rdata_o
);

   localparam logic [AddrW:0] DepthW = (AddrW + 1)'(Depth);

   logic [Width-1:0]            mem_q [Depth];
   logic [NumRd-1:0][Width-1:0] rdata_q;
   logic                        wr_ok;

   assign wr_ok = we_i && ({1'b0, waddr_i} < DepthW);

   // Contents survive reset; writes are only blocked while reset is asserted.
   always_ff @(posedge clk_i) begin
      if (rst_ni && wr_ok) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else begin
         for (int p = 0; p < int'(NumRd); p++) begin
            if ({1'b0, raddr_i[p]} < DepthW) begin
               rdata_q[p] <= mem_q[raddr_i[p]];
            end else begin
               rdata_q[p] <= '0;
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/me_pixel_memory.sv
// Reference-block and search-window pixel storage: one R read port, two S read ports, one loader.
module me_pixel_memory #(
   parameter int unsigned PIX_W = me_pkg::PIX_W,
   parameter int unsigned R_DIM = me_pkg::R_DIM,
   parameter int unsigned S_DIM = me_pkg::S_DIM
) (
   input  logic                    clock,
   input  logic                    rst_n,
   input  logic [me_pkg::R_AW-1:0] AddressR,
   input  logic [me_pkg::S_AW-1:0] AddressS1,
   input  logic [me_pkg::S_AW-1:0] AddressS2,
   output logic [PIX_W-1:0]        R,
   output logic [PIX_W-1:0]        S1,
   output logic [PIX_W-1:0]        S2,
   input  logic                    load_en,
   input  logic                    load_sel,
   input  logic [me_pkg::S_AW-1:0] load_addr,
   input  logic [PIX_W-1:0]        load_data,
   output logic                    load_err
);

   import me_pkg::*;

   localparam int unsigned         RDepth = R_DIM * R_DIM;
   localparam int unsigned         SDepth = S_DIM * S_DIM;
   localparam logic [S_AW-1:0]     SLimit = S_AW'(SDepth);

   mem_sel_e               sel;
   logic                   we_r;
   logic                   we_s;
   logic                   load_err_d;
   logic                   load_err_q;
   logic [0:0][PIX_W-1:0]  r_rd;
   logic [1:0][PIX_W-1:0]  s_rd;

   assign sel  = mem_sel_e'(load_sel);
   assign we_r = load_en && (sel == SEL_R);
   assign we_s = load_en && (sel == SEL_S);

   always_comb begin
      load_err_d = 1'b0;
      if (we_s && (load_addr >= SLimit)) begin
         load_err_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= load_err_d;
      end
   end

   me_sync_ram #(
      .Width (PIX_W),
      .Depth (RDepth),
      .AddrW (R_AW),
      .NumRd (1)
   ) u_ram_r (
      .clk_i   (clock),
      .rst_ni  (rst_n),
      .we_i    (we_r),
      .waddr_i (load_addr[R_AW-1:0]),
      .wdata_i (load_data),
      .raddr_i (AddressR),
      .rdata_o (r_rd)
   );

   me_sync_ram #(
      .Width (PIX_W),
      .Depth (SDepth),
      .AddrW (S_AW),
      .NumRd (2)
   ) u_ram_s (
      .clk_i   (clock),
      .rst_ni  (rst_n),
      .we_i    (we_s),
      .waddr_i (load_addr),
      .wdata_i (load_data),
      .raddr_i ({AddressS2, AddressS1}),
      .rdata_o (s_rd)
   );

   assign R        = r_rd[0];
   assign S1       = s_rd[0];
   assign S2       = s_rd[1];
   assign load_err = load_err_q;

endmodule

// File: tb/tb_me_pixel_memory.sv
// Directed plus randomized checks of me_pixel_memory against an array-based reference model.
module tb_me_pixel_memory;

   logic       clock;
   logic       rst_n;
   logic [7:0] AddressR;
   logic [9:0] AddressS1;
   logic [9:0] AddressS2;
   logic [7:0] R;
   logic [7:0] S1;
   logic [7:0] S2;
   logic       load_en;
   logic       load_sel;
   logic [9:0] load_addr;
   logic [7:0] load_data;
   logic       load_err;

   int tests;
   int fails;

   int ref_r [256];
   int ref_s [961];

   me_pixel_memory u_dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .AddressR  (AddressR),
      .AddressS1 (AddressS1),
      .AddressS2 (AddressS2),
      .R         (R),
      .S1        (S1),
      .S2        (S2),
      .load_en   (load_en),
      .load_sel  (load_sel),
      .load_addr (load_addr),
      .load_data (load_data),
      .load_err  (load_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int s_read(input int a);
      return (a < 961) ? ref_s[a] : 0;
   endfunction

   initial begin
      int ar, a1, a2, wa, wd, sel, en;
      int exp_r, exp_s1, exp_s2, exp_err;
      tests     = 0;
      fails     = 0;
      rst_n     = 1'b0;
      AddressR  = '0;
      AddressS1 = '0;
      AddressS2 = '0;
      load_en   = 1'b0;
      load_sel  = 1'b0;
      load_addr = '0;
      load_data = '0;

      // Reset state
      #1;
      check("reset_R", 32'(R), 0);
      check("reset_S1", 32'(S1), 0);
      check("reset_S2", 32'(S2), 0);
      check("reset_err", 32'(load_err), 0);
      tick();
      tick();
      rst_n = 1'b1;

      // R fill and sweep
      load_en  = 1'b1;
      load_sel = 1'b0;
      for (int i = 0; i < 256; i++) begin
         load_addr = 10'(i);
         load_data = 8'(i);
         ref_r[i]  = i;
         tick();
      end
      load_en = 1'b0;
      for (int i = 0; i < 256; i++) begin
         AddressR = 8'(i);
         tick();
         check("r_sweep", 32'(R), 32'(i));
      end
      check("r_255", 32'(R), 32'hFF);

      // S fill with i mod 256
      load_en  = 1'b1;
      load_sel = 1'b1;
      for (int i = 0; i < 961; i++) begin
         load_addr = 10'(i);
         load_data = 8'(i % 256);
         ref_s[i]  = i % 256;
         tick();
      end
      load_en = 1'b0;

      AddressS1 = 10'd0;
      AddressS2 = 10'd960;
      tick();
      check("s_dual_s1_0", 32'(S1), 0);
      check("s_dual_s2_960", 32'(S2), 32'hC0);
      AddressS1 = 10'd500;
      AddressS2 = 10'd500;
      tick();
      check("s_same_s1", 32'(S1), 32'hF4);
      check("s_same_s2", 32'(S2), 32'hF4);

      // Out-of-range S
      AddressS1 = 10'd961;
      tick();
      check("s_oor_read", 32'(S1), 0);
      load_en   = 1'b1;
      load_sel  = 1'b1;
      load_addr = 10'd1000;
      load_data = 8'h77;
      tick();
      load_en = 1'b0;
      check("err_set", 32'(load_err), 1);
      AddressS1 = 10'd39;
      AddressS2 = 10'd960;
      tick();
      check("err_clear", 32'(load_err), 0);
      check("oor_no_alias", 32'(S1), 32'd39);
      check("oor_no_corrupt", 32'(S2), 32'hC0);

      // Read-before-write
      load_en   = 1'b1;
      load_sel  = 1'b1;
      load_addr = 10'd10;
      load_data = 8'h11;
      tick();
      AddressS1 = 10'd10;
      load_data = 8'h22;
      tick();
      load_en   = 1'b0;
      ref_s[10] = 8'h22;
      check("rbw_old", 32'(S1), 32'h11);
      tick();
      check("rbw_new", 32'(S1), 32'h22);

      // R address ignores load_addr[9:8]
      load_en   = 1'b1;
      load_sel  = 1'b0;
      load_addr = 10'h3_05;
      load_data = 8'hA5;
      tick();
      ref_r[5]  = 8'hA5;
      load_sel  = 1'b1;
      load_addr = 10'd7;
      load_data = 8'h5A;
      tick();
      ref_s[7]  = 8'h5A;
      AddressR  = 8'd5;
      AddressS1 = 10'd7;
      AddressS2 = 10'd7;
      load_addr = 10'd1023;
      tick();
      load_en = 1'b0;
      check("r_hi_bits_ignored", 32'(R), 32'hA5);
      check("pre_rst_S1", 32'(S1), 32'h5A);
      check("pre_rst_err", 32'(load_err), 1);

      // Asynchronous reset mid-cycle; writes during reset are ignored
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_R", 32'(R), 0);
      check("mid_rst_S1", 32'(S1), 0);
      check("mid_rst_S2", 32'(S2), 0);
      check("mid_rst_err", 32'(load_err), 0);
      load_en   = 1'b1;
      load_sel  = 1'b0;
      load_addr = 10'd5;
      load_data = 8'h00;
      tick();
      check("rst_hold_R", 32'(R), 0);
      load_en = 1'b0;
      rst_n   = 1'b1;
      tick();
      check("post_rst_R", 32'(R), 32'hA5);
      check("post_rst_S1", 32'(S1), 32'h5A);
      check("post_rst_S2", 32'(S2), 32'h5A);

      // Randomized concurrent reads and writes
      for (int n = 0; n < 400; n++) begin
         ar  = int'($urandom_range(255));
         a1  = ($urandom_range(7) == 0) ? int'($urandom_range(1023, 961))
                                         : int'($urandom_range(960));
         a2  = ($urandom_range(3) == 0) ? a1 : int'($urandom_range(1023));
         en  = int'($urandom_range(1));
         sel = int'($urandom_range(1));
         wa  = ($urandom_range(5) == 0) ? int'($urandom_range(1023, 961))
                                         : int'($urandom_range(960));
         wd  = int'($urandom_range(255));
         exp_r   = ref_r[ar];
         exp_s1  = s_read(a1);
         exp_s2  = s_read(a2);
         exp_err = (en == 1 && sel == 1 && wa >= 961) ? 1 : 0;
         AddressR  = 8'(ar);
         AddressS1 = 10'(a1);
         AddressS2 = 10'(a2);
         load_en   = en[0];
         load_sel  = sel[0];
         load_addr = 10'(wa);
         load_data = 8'(wd);
         tick();
         if (en == 1 && sel == 0) ref_r[wa % 256] = wd;
         if (en == 1 && sel == 1 && wa < 961) ref_s[wa] = wd;
         check("rand_R", 32'(R), 32'(exp_r));
         check("rand_S1", 32'(S1), 32'(exp_s1));
         check("rand_S2", 32'(S2), 32'(exp_s2));
         check("rand_err", 32'(load_err), 32'(exp_err));
      end
      load_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
